// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Serves single-word reads and writes from the pipeline's MEM stage and
// stalls the core on a miss. Lines are fetched from and evicted to a slow
// line-wide memory using a level request plus ready handshake.
module data_cache #(
  parameter int NUM_LINES = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 28 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state;

  // Line storage is kept packed so that a whole-array clear is one assignment
  // and word selection within a line is a plain index.
  logic [NUM_LINES-1:0]             valid;
  logic [NUM_LINES-1:0]             dirty;
  logic [NUM_LINES-1:0][TAG_W-1:0]  tags;
  logic [NUM_LINES-1:0][3:0][31:0]  lines;

  logic               req;
  logic               hit;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   addr_tag;
  logic [1:0]         offset;

  assign req      = proc_read | proc_write;
  assign index    = proc_addr[INDEX_W+1:2];
  assign addr_tag = proc_addr[29:INDEX_W+2];
  assign offset   = proc_addr[1:0];
  assign hit      = req & valid[index] & (tags[index] == addr_tag);

  // The core is frozen whenever a line transfer is in flight or the current
  // request cannot be served from the array this cycle.
  assign proc_stall = (state != IDLE) | (req & ~hit);

  // Read data is an ungated array lookup so read hits complete with zero latency.
  assign proc_rdata = lines[index][offset];

  // Miss handling FSM: evict a dirty victim, fetch the requested line, then
  // let the held request hit in IDLE; also performs write hits in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      valid     <= '0;
      dirty     <= '0;
      tags      <= '0;
      lines     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (proc_write) begin
                lines[index][offset] <= proc_wdata;
                dirty[index]         <= 1'b1;
              end
            end else if (valid[index] && dirty[index]) begin
              state     <= WRITEBACK;
              mem_write <= 1'b1;
              mem_addr  <= {tags[index], index};
              mem_wdata <= lines[index];
            end else begin
              state    <= ALLOCATE;
              mem_read <= 1'b1;
              mem_addr <= proc_addr[29:2];
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            state     <= ALLOCATE;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= proc_addr[29:2];
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            state        <= IDLE;
            mem_read     <= 1'b0;
            lines[index] <= mem_rdata;
            tags[index]  <= addr_tag;
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache. A reference model of the processor-visible
// memory plus per-set residency predicts each request's read data, stall
// length and memory traffic; a monitor compares when each request completes.
module tb_data_cache;

  localparam int NUM_LINES = 8;

  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  data_cache #(.NUM_LINES(NUM_LINES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  typedef struct {
    bit           read_only;
    logic [31:0]  rdata;
    int           n_rd;
    int           n_wr;
    logic [27:0]  fetch_addr;
    logic [27:0]  wb_addr;
    logic [127:0] wb_data;
    int           stall_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   delay_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   spurious_en = 0;

  // Reference model: processor view of memory, memory image, set residency.
  logic [31:0]  view    [logic [29:0]];
  logic [31:0]  mem_img [logic [29:0]];
  bit           res_valid [NUM_LINES];
  bit           res_dirty [NUM_LINES];
  logic [27:0]  res_line  [NUM_LINES];

  // Responder backing store, filled only by actual DUT write-backs.
  logic [127:0] backing [logic [27:0]];
  bit           resp_active;
  int           resp_cnt;

  // Monitor bookkeeping.
  int           stall_cnt;
  int           rd_hs;
  int           wr_hs;
  logic [27:0]  rd_addr;
  logic [27:0]  wr_addr;
  logic [127:0] wr_data;
  exp_t         got;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return ({2'b00, wa} * 32'h9E3779B1) ^ 32'hA5A51234;
  endfunction

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    if (mem_img.exists(wa)) return mem_img[wa];
    return init_word(wa);
  endfunction

  function automatic logic [31:0] view_word(input logic [29:0] wa);
    if (view.exists(wa)) return view[wa];
    return mem_word(wa);
  endfunction

  function automatic logic [127:0] backing_line(input logic [27:0] la);
    logic [127:0] l;
    logic [1:0]   ww;
    if (backing.exists(la)) return backing[la];
    for (int w = 0; w < 4; w++) begin
      ww = 2'(w);
      l[32*w +: 32] = init_word({la, ww});
    end
    return l;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    view.delete();
    for (int i = 0; i < NUM_LINES; i++) begin
      res_valid[i] = 1'b0;
      res_dirty[i] = 1'b0;
      res_line[i]  = '0;
    end
  endtask

  function automatic int pick_delay(input int d);
    if (d >= 0) return d;
    return int'($urandom_range(0, 3));
  endfunction

  // Predicts the request's outcome, queues it, drives it and holds it until done.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [29:0] addr,
                               input logic [31:0] wdata, input int d_wb, input int d_rd);
    exp_t        e;
    logic [27:0] la;
    int          line_set;
    int          dd;
    bit          done;
    logic [1:0]  ww;
    logic [31:0] word;
    la            = addr[29:2];
    line_set      = int'(la % 28'(NUM_LINES));
    e.read_only   = rd && !wr;
    e.rdata       = '0;
    e.n_rd        = 0;
    e.n_wr        = 0;
    e.fetch_addr  = '0;
    e.wb_addr     = '0;
    e.wb_data     = '0;
    e.stall_cycles = 0;
    if (!(res_valid[line_set] && res_line[line_set] == la)) begin
      e.stall_cycles = 1;
      if (res_valid[line_set] && res_dirty[line_set]) begin
        e.n_wr    = 1;
        e.wb_addr = res_line[line_set];
        for (int w = 0; w < 4; w++) begin
          ww   = 2'(w);
          word = view_word({res_line[line_set], ww});
          e.wb_data[32*w +: 32] = word;
          mem_img[{res_line[line_set], ww}] = word;
        end
        dd = pick_delay(d_wb);
        delay_q.push_back(dd);
        e.stall_cycles += dd + 1;
      end
      e.n_rd       = 1;
      e.fetch_addr = la;
      dd = pick_delay(d_rd);
      delay_q.push_back(dd);
      e.stall_cycles += dd + 1;
      res_valid[line_set] = 1'b1;
      res_dirty[line_set] = 1'b0;
      res_line[line_set]  = la;
    end
    if (e.read_only) e.rdata = view_word(addr);
    if (wr) begin
      view[addr] = wdata;
      res_dirty[line_set] = 1'b1;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = addr;
    proc_wdata = wdata;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!proc_stall) done = 1'b1;
    end
    if (!done) begin
      $display("[TB] FAIL request_timeout: addr 0x%0h still stalled, required completion within 100 cycles", addr);
      $fatal(1, "[TB] request timeout");
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      proc_read  = 1'b0;
      proc_write = 1'b0;
    end
  endtask

  // Memory responder: raises ready after the queued delay for each new request,
  // and optionally emits stray ready pulses while no request is outstanding.
  initial begin
    mem_ready   = 1'b0;
    mem_rdata   = '0;
    resp_active = 1'b0;
    resp_cnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_ready   = 1'b0;
        resp_active = 1'b0;
      end else if (mem_read || mem_write) begin
        if (!resp_active) begin
          resp_active = 1'b1;
          resp_cnt    = (delay_q.size() > 0) ? delay_q.pop_front() : 1;
        end
        if (resp_cnt == 0) begin
          mem_ready   = 1'b1;
          resp_active = 1'b0;
          if (mem_write) backing[mem_addr] = mem_wdata;
          else mem_rdata = backing_line(mem_addr);
        end else begin
          mem_ready = 1'b0;
          resp_cnt--;
        end
      end else begin
        resp_active = 1'b0;
        if (spurious_en && $urandom_range(0, 3) == 0) begin
          mem_ready = 1'b1;
          mem_rdata = {4{$urandom()}};
        end else begin
          mem_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: tracks handshakes and stall cycles, checks each completed request.
  initial begin
    stall_cnt = 0;
    rd_hs     = 0;
    wr_hs     = 0;
    rd_addr   = '0;
    wr_addr   = '0;
    wr_data   = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        stall_cnt = 0;
        rd_hs     = 0;
        wr_hs     = 0;
      end else begin
        checkOutput("mem_rd_wr_exclusive", 128'(mem_read & mem_write), 128'(0));
        if (mem_ready && mem_read) begin
          rd_hs++;
          rd_addr = mem_addr;
        end
        if (mem_ready && mem_write) begin
          wr_hs++;
          wr_addr = mem_addr;
          wr_data = mem_wdata;
        end
        if (proc_read || proc_write) begin
          if (proc_stall) begin
            stall_cnt++;
          end else begin
            if (exp_q.size() == 0) begin
              checkOutput("unexpected_completion", 128'(1), 128'(0));
            end else begin
              got = exp_q.pop_front();
              if (got.read_only) checkOutput("proc_rdata", 128'(proc_rdata), 128'(got.rdata));
              checkOutput("stall_cycles", 128'(stall_cnt), 128'(got.stall_cycles));
              checkOutput("line_fetches", 128'(rd_hs), 128'(got.n_rd));
              checkOutput("line_writebacks", 128'(wr_hs), 128'(got.n_wr));
              if (got.n_rd > 0) checkOutput("fetch_addr", 128'(rd_addr), 128'(got.fetch_addr));
              if (got.n_wr > 0) begin
                checkOutput("writeback_addr", 128'(wr_addr), 128'(got.wb_addr));
                checkOutput("writeback_data", wr_data, got.wb_data);
              end
              checkOutput("mem_idle_on_done", 128'({mem_read, mem_write}), 128'(0));
            end
            stall_cnt = 0;
            rd_hs     = 0;
            wr_hs     = 0;
          end
        end
      end
    end
  end

  // Main sequence: reset checks, directed scenarios, then randomized traffic.
  initial begin
    logic [24:0] tag_pool [5];
    logic [24:0] tagv;
    logic [2:0]  idx;
    logic [1:0]  off;
    int          op;
    tag_pool[0] = 25'h0;
    tag_pool[1] = 25'h1;
    tag_pool[2] = 25'h2;
    tag_pool[3] = 25'h3;
    tag_pool[4] = 25'h1FFFFFF;
    rst_n      = 1'b0;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    resetModel();

    repeat (2) @(negedge clk);
    checkOutput("reset_proc_stall", 128'(proc_stall), 128'(0));
    checkOutput("reset_mem_read", 128'(mem_read), 128'(0));
    checkOutput("reset_mem_write", 128'(mem_write), 128'(0));
    checkOutput("reset_mem_addr", 128'(mem_addr), 128'(0));
    checkOutput("reset_mem_wdata", mem_wdata, 128'(0));
    checkOutput("reset_proc_rdata", 128'(proc_rdata), 128'(0));
    proc_read = 1'b1;
    proc_addr = 30'h10;
    #1;
    checkOutput("reset_req_stalls", 128'(proc_stall), 128'(1));
    proc_read = 1'b0;
    #1;
    rst_n = 1'b1;

    // Cold read miss, then a hit on the same line.
    applyStimulus(1'b1, 1'b0, 30'h10, 32'h0, -1, 3);
    applyStimulus(1'b1, 1'b0, 30'h11, 32'h0, -1, -1);
    // Write hit followed immediately by a read of the written word.
    applyStimulus(1'b0, 1'b1, 30'h12, 32'hDEADBEEF, -1, -1);
    applyStimulus(1'b1, 1'b0, 30'h12, 32'h0, -1, -1);
    // Conflict miss on a dirty line: write-back then fetch.
    applyStimulus(1'b1, 1'b0, 30'h30, 32'h0, 2, 2);
    // Write miss on a clean line, then evict it.
    applyStimulus(1'b0, 1'b1, 30'h50, 32'h13579BDF, -1, 0);
    idleCycles(2);
    applyStimulus(1'b1, 1'b0, 30'h10, 32'h0, 0, 1);
    idleCycles(1);

    // Reset in the middle of a line fetch.
    @(posedge clk);
    #2;
    delay_q.push_back(8);
    proc_read  = 1'b1;
    proc_write = 1'b0;
    proc_addr  = 30'h90;
    repeat (3) @(negedge clk);
    checkOutput("alloc_mem_read", 128'(mem_read), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_mem_read", 128'(mem_read), 128'(0));
    checkOutput("abort_mem_write", 128'(mem_write), 128'(0));
    checkOutput("abort_req_stalls", 128'(proc_stall), 128'(1));
    resetModel();
    delay_q.delete();
    proc_read = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Stray ready pulses while idle must not disturb anything.
    spurious_en = 1'b1;
    idleCycles(12);
    applyStimulus(1'b1, 1'b0, 30'h10, 32'h0, -1, -1);
    applyStimulus(1'b1, 1'b0, 30'h12, 32'h0, -1, -1);

    // Randomized traffic over a small set of conflicting tags.
    for (int n = 0; n < 300; n++) begin
      spurious_en = ($urandom_range(0, 1) == 1);
      tagv = tag_pool[$urandom_range(0, 4)];
      idx  = 3'($urandom_range(0, 7));
      off  = 2'($urandom_range(0, 3));
      op   = int'($urandom_range(0, 9));
      applyStimulus(op < 5 || op == 9, op >= 5, {tagv, idx, off}, $urandom(), -1, -1);
      if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 3)));
    end

    idleCycles(2);
    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
